// File: rtl/seven_seg_scan_decoder_if.sv
// Display bus seen by the scan decoder: multiplexed segment/anode lines in,
// reassembled MM:SS frame and status flags out.
interface seven_seg_scan_decoder_if;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        err_clr;
    logic [15:0] digits;
    logic        frame_valid;
    logic        frame_changed;
    logic        err;
    logic        active;

    modport master (
        output seg_in,
        output an_in,
        output err_clr,
        input  digits,
        input  frame_valid,
        input  frame_changed,
        input  err,
        input  active
    );

    modport slave (
        input  seg_in,
        input  an_in,
        input  err_clr,
        output digits,
        output frame_valid,
        output frame_changed,
        output err,
        output active
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Samples a multiplexed 4-digit seven-segment bus and rebuilds BCD MM:SS
// frames with valid/changed/error/activity flags.
module seven_seg_scan_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4,
    parameter int TIMEOUT     = 65535
) (
    input logic                    clk,
    input logic                    rst,
    seven_seg_scan_decoder_if.slave bus
);

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic [10:0]                  prev_q;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                cnt_d;
    logic [3:0][3:0]              stg_q;
    logic [3:0][3:0]              stg_d;
    logic [3:0]                   mask_q;
    logic [3:0]                   mask_d;
    logic                         fire_q;
    logic                         fire_d;
    logic [TW-1:0]                to_q;
    logic [TW-1:0]                to_d;
    logic                         active_q;
    logic                         active_d;
    logic [15:0]                  digits_q;
    logic [15:0]                  digits_d;
    logic                         fv_q;
    logic                         fv_d;
    logic                         fc_q;
    logic                         fc_d;
    logic                         err_q;
    logic                         err_d;

    logic [10:0] smp;
    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic [3:0]  sel;
    logic        cand;
    logic        same;
    logic        cap;
    logic [3:0]  dec;
    logic        illegal;
    logic        dark;

    assign smp   = sync_q[SYNC_STAGES-1];
    assign an_s  = smp[10:7];
    assign seg_s = smp[6:0];
    assign sel   = ~an_s;

    // Exactly one anode low; blanking and ghosting are not candidates.
    assign cand = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    assign same = (smp == prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {bus.an_in, bus.seg_in}};
        end
    end

    always_comb begin
        cnt_d = '0;
        if (!cand) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q == SETTLE_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fire once on reaching SETTLE; a saturated dwell does not re-fire.
    assign cap = cand && (cnt_d == SETTLE_C) && !(same && cnt_q == SETTLE_C);

    always_comb begin
        dec     = 4'hF;
        illegal = 1'b0;
        unique case (seg_s)
            7'b1000000: dec = 4'd0;
            7'b1111001: dec = 4'd1;
            7'b0100100: dec = 4'd2;
            7'b0110000: dec = 4'd3;
            7'b0011001: dec = 4'd4;
            7'b0010010: dec = 4'd5;
            7'b0000010: dec = 4'd6;
            7'b1111000: dec = 4'd7;
            7'b0000000: dec = 4'd8;
            7'b0010000: dec = 4'd9;
            default: begin
                dec     = 4'hF;
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        to_d = to_q;
        if (cap) begin
            to_d = '0;
        end else if (to_q != TIMEOUT_C) begin
            to_d = to_q + TW'(1);
        end
    end

    assign dark = !cap && (to_d == TIMEOUT_C);

    always_comb begin
        active_d = active_q;
        if (cap) begin
            active_d = 1'b1;
        end else if (dark) begin
            active_d = 1'b0;
        end
    end

    always_comb begin
        stg_d  = stg_q;
        mask_d = mask_q;
        fire_d = 1'b0;
        if (cap) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    stg_d[i] = dec;
                end
            end
            mask_d = mask_q | sel;
            if (&mask_d) begin
                fire_d = 1'b1;
                mask_d = 4'd0;
            end
        end
        // A display gone dark abandons whatever partial frame was collected.
        if (dark) begin
            mask_d = 4'd0;
        end
    end

    always_comb begin
        digits_d = digits_q;
        fv_d     = fire_q;
        fc_d     = 1'b0;
        if (fire_q) begin
            digits_d = stg_q;
            fc_d     = (stg_q != digits_q);
        end
    end

    assign err_d = (cap && illegal) || (err_q && !bus.err_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            stg_q    <= '0;
            mask_q   <= '0;
            fire_q   <= 1'b0;
            to_q     <= '0;
            active_q <= 1'b0;
            digits_q <= '0;
            fv_q     <= 1'b0;
            fc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= smp;
            cnt_q    <= cnt_d;
            stg_q    <= stg_d;
            mask_q   <= mask_d;
            fire_q   <= fire_d;
            to_q     <= to_d;
            active_q <= active_d;
            digits_q <= digits_d;
            fv_q     <= fv_d;
            fc_q     <= fc_d;
            err_q    <= err_d;
        end
    end

    assign bus.digits        = digits_q;
    assign bus.frame_valid   = fv_q;
    assign bus.frame_changed = fc_q;
    assign bus.err           = err_q;
    assign bus.active        = active_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: scans digit sequences onto the
// display bus and checks reassembled frames and flags against fixed values.
module tb_seven_seg_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scan_decoder_if bus ();

    seven_seg_scan_decoder #(
        .SYNC_STAGES(2),
        .SETTLE     (4),
        .TIMEOUT    (100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          fv_cnt = 0;
    int          fv_idx = -1;
    int          run = 0;
    int          run_max = 0;
    int          f0;
    logic        fc_last = 1'b0;
    logic [15:0] dig_last = '0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'b1000000;
            4'd1: enc = 7'b1111001;
            4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000;
            4'd4: enc = 7'b0011001;
            4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010;
            4'd7: enc = 7'b1111000;
            4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    // Hold pins for n cycles, watching frame_valid on every falling edge.
    task automatic show(input logic [3:0] an, input logic [6:0] seg,
                        input int n);
        @(posedge clk);
        #1;
        bus.an_in  = an;
        bus.seg_in = seg;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.frame_valid) begin
                fv_cnt++;
                fv_idx   = i;
                fc_last  = bus.frame_changed;
                dig_last = bus.digits;
                run++;
            end else begin
                run = 0;
            end
            if (run > run_max) run_max = run;
        end
    endtask

    task automatic dig(input int k, input logic [3:0] v);
        logic [3:0] an;
        an = 4'b0001 << k;
        show(~an, enc(v), 16);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            dig(k, v[4*k +: 4]);
        end
    endtask

    initial begin
        bus.seg_in  = 7'h7F;
        bus.an_in   = 4'hF;
        bus.err_clr = 1'b0;

        show(4'hF, 7'h7F, 4);
        check_eq("rst_digits", bus.digits, 16'h0);
        check_eq("rst_fv", bus.frame_valid, 1'b0);
        check_eq("rst_fc", bus.frame_changed, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        check_eq("rst_active", bus.active, 1'b0);
        rst = 1'b0;

        f0 = fv_cnt;
        scan(16'h1234);
        check_eq("basic_cnt", fv_cnt, f0 + 1);
        check_eq("basic_digits", dig_last, 16'h1234);
        check_eq("basic_fc", fc_last, 1'b1);
        check_eq("basic_latency", fv_idx, 7);
        check_eq("basic_active", bus.active, 1'b1);

        f0 = fv_cnt;
        scan(16'h1234);
        check_eq("repeat_cnt", fv_cnt, f0 + 1);
        check_eq("repeat_digits", dig_last, 16'h1234);
        check_eq("repeat_fc", fc_last, 1'b0);

        f0 = fv_cnt;
        dig(0, 4'd5);
        show(4'b1101, enc(4'd8), 3);
        show(4'b0011, enc(4'd8), 16);
        dig(2, 4'd9);
        dig(3, 4'd0);
        check_eq("glitch_noframe", fv_cnt, f0);
        check_eq("glitch_digits", bus.digits, 16'h1234);
        dig(1, 4'd6);
        check_eq("glitch_cnt", fv_cnt, f0 + 1);
        check_eq("glitch_frame", dig_last, 16'h0965);
        check_eq("glitch_fc", fc_last, 1'b1);

        f0 = fv_cnt;
        show(4'b1110, 7'b1111111, 16);
        dig(1, 4'd4);
        dig(2, 4'd2);
        dig(3, 4'd1);
        check_eq("illegal_cnt", fv_cnt, f0 + 1);
        check_eq("illegal_digits", dig_last, 16'h124F);
        check_eq("illegal_err", bus.err, 1'b1);
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        @(negedge clk);
        check_eq("err_hold", bus.err, 1'b1);
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        check_eq("err_clr", bus.err, 1'b0);

        f0 = fv_cnt;
        dig(2, 4'd3);
        dig(0, 4'd1);
        dig(0, 4'd7);
        dig(3, 4'd2);
        check_eq("ovr_partial", fv_cnt, f0);
        dig(1, 4'd8);
        check_eq("ovr_cnt", fv_cnt, f0 + 1);
        check_eq("ovr_digits", dig_last, 16'h2387);

        f0 = fv_cnt;
        dig(0, 4'd1);
        dig(1, 4'd1);
        dig(2, 4'd1);
        show(4'hF, 7'h7F, 90);
        check_eq("to_active_hi", bus.active, 1'b1);
        show(4'hF, 7'h7F, 1);
        check_eq("to_active_lo", bus.active, 1'b0);
        check_eq("to_noframe", fv_cnt, f0);
        dig(3, 4'd4);
        check_eq("to_discard", fv_cnt, f0);
        check_eq("to_reactive", bus.active, 1'b1);
        dig(0, 4'd1);
        dig(1, 4'd2);
        dig(2, 4'd3);
        check_eq("to_cnt", fv_cnt, f0 + 1);
        check_eq("to_digits", dig_last, 16'h4321);

        show(4'b1110, 7'b1111111, 16);
        check_eq("mid_err", bus.err, 1'b1);
        dig(1, 4'd3);
        rst = 1'b1;
        show(4'hF, 7'h7F, 3);
        check_eq("mid_digits", bus.digits, 16'h0);
        check_eq("mid_fv", bus.frame_valid, 1'b0);
        check_eq("mid_fc", bus.frame_changed, 1'b0);
        check_eq("mid_err_clr", bus.err, 1'b0);
        check_eq("mid_active", bus.active, 1'b0);
        rst = 1'b0;
        f0 = fv_cnt;
        dig(2, 4'd9);
        dig(3, 4'd5);
        check_eq("mid_discard", fv_cnt, f0);
        dig(0, 4'd9);
        dig(1, 4'd5);
        check_eq("mid_cnt", fv_cnt, f0 + 1);
        check_eq("mid_frame", dig_last, 16'h5959);
        check_eq("mid_fc_new", fc_last, 1'b1);

        check_eq("fv_run", run_max, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receiver for the stopwatch's multiplexed four-digit seven-segment display bus. It samples the segment and anode lines and decodes each segment pattern back to a BCD digit. It then reassembles complete MM:SS frames and reports them with valid, change and error flags. It is used as an on-chip display monitor and as a synthesizable checker on the far end of the display interface.

## Interface

Parameters:

- SYNC_STAGES, 2: flops in the input synchronizer for seg_in/an_in (minimum 2).
- SETTLE, 4: consecutive identical synchronized samples required before a digit is captured (minimum 1).
- TIMEOUT, 65535: cycles without any capture after which the display is declared dark.

Ports:

- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines, active-low, seg_in[0]=a … seg_in[6]=g.
- an_in  in  4  anode lines, active-low. an_in[0]=seconds ones, [1]=seconds tens, [2]=minutes ones, [3]=minutes tens.
- err_clr  in  1  one-cycle pulse that clears err.
- digits  out  16  last complete frame in BCD: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- frame_valid  out  1  one-cycle pulse when digits is updated.
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous one.
- err  out  1  sticky flag for an illegal segment pattern.
- active  out  1  high while captures keep arriving within TIMEOUT.

## Operation

- **Synchronizer.** seg_in and an_in (11 bits) pass through a SYNC_STAGES-deep flop chain. All further logic uses only the synchronized copy.
- **Anode select.**
  - The sample is a candidate only if exactly one anode bit is low.
  - All-high (blanking) and multiple-low (ghosting) samples are ignored, and they reset the settle counter.
- **Settle counter.**
  - Increments while the synchronized {an,seg} equals the previous cycle's value and the sample is a candidate.
  - Resets to 1 on any change.
  - A capture fires once, on the cycle the count reaches SETTLE.
  - No further capture occurs until the pattern changes, even if it dwells longer.
- **Decode (active-low seg, bits gfedcba).** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other pattern stores 4'hF into the digit and sets err.
- **Capture.** Writes the decoded value into the staging register selected by the anode and sets that bit of a 4-bit seen mask.
  - Re-capturing a digit already in the mask overwrites it; the latest value wins.
- **Frame.** On the capture that makes the mask 1111:
  - Next cycle: digits <= staging, frame_valid=1, and frame_changed=1 if staging differs from the prior digits.
  - Same edge as the completing capture: the mask clears to 0000. A capture on the following cycle starts the next frame.
- **Activity.**
  - The timeout counter clears on every capture and saturates at TIMEOUT.
  - active=1 after the first capture and drops to 0 when the counter reaches TIMEOUT.
  - When active drops, the seen mask clears so that a partial frame is discarded.
- **Error.** err is set by an illegal pattern and cleared by err_clr or rst. If err_clr and a new illegal capture occur in the same cycle, set wins.
- **Reset.** rst clears every register:
  - digits=0, frame_valid=0, frame_changed=0, err=0, active=0.
  - Mask, staging registers, settle counter, timeout counter and synchronizer all clear.
  - A reset mid-frame discards the partial frame.

## Timing

- Capture latency: a pattern stable at the pins from edge 0 is captured at edge SYNC_STAGES+SETTLE-1.
- Frame latency: frame_valid is high for exactly one cycle, SYNC_STAGES+SETTLE cycles after the completing digit appears at the pins (defaults: 6).
- frame_valid and frame_changed are never high for more than one consecutive cycle.
- A dwell shorter than SETTLE synchronized cycles produces no capture.
- active falls exactly TIMEOUT cycles after the last capture edge.
- Outputs are fully registered, with no combinational path from inputs.

## Test plan

- **Basic frame.** Scan 12:34 (each anode held 16 cycles, digits in order 0→3) → one frame_valid with digits=16'h1234 and frame_changed=1. Repeating the same scan → frame_valid with frame_changed=0.
- **Glitch rejection.** Insert a 3-cycle pattern for digit 8 between digits (defaults) → no capture and digits unchanged. Ghosting with an_in=4'b0011 → ignored.
- **Illegal pattern.** Drive seg_in=7'b1111111 with an_in=4'b1110, then complete the frame → digits[3:0]=4'hF and err=1. err_clr → err=0 on the next cycle.
- **Overwrite and out-of-order scan.** Scan order 2,0,0(new value 7),3,1 → a single frame with the latest digit-0 value 7.
- **Timeout.** TIMEOUT=100: stop scanning after 3 digits → active=0 at 100 cycles and no frame_valid. A full scan afterwards → one correct frame.
- **Reset mid-frame.** Assert rst after 2 captures → all outputs 0. The next full 59:59 scan → digits=16'h5959.
